// File: rtl/alu_mul_sequencer.sv
// rtl/alu_mul_sequencer.sv - shift/add unsigned multiply sequencer driving a shared W-bit ALU
module alu_mul_sequencer #(
    parameter int              W      = 8,
    parameter int              Ops    = 3,
    parameter logic [Ops-1:0]  OP_ADD = Ops'(0),
    parameter logic [Ops-1:0]  OP_LSH = Ops'(4)
) (
    input  logic             Clk,
    input  logic             Reset_n,
    input  logic             Start,
    input  logic [W-1:0]     OpA,
    input  logic [W-1:0]     OpB,
    output logic             Busy,
    output logic             Done,
    output logic [2*W-1:0]   Product,
    output logic [W-1:0]     AluA,
    output logic [W-1:0]     AluB,
    output logic [Ops-1:0]   AluOp,
    output logic             AluSC,
    input  logic [W-1:0]     AluOut
);

    localparam int CW = (W > 1) ? $clog2(W) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SHL_LO,
        S_SHL_HI,
        S_ADD_LO,
        S_ADD_HI,
        S_DONE
    } state_t;

    state_t         state;
    state_t         state_nxt;
    logic [W-1:0]   a_reg;
    logic [W-1:0]   b_reg;
    logic [W-1:0]   hi;
    logic [W-1:0]   lo;
    logic [CW-1:0]  cnt;
    logic           carry;
    logic           lo_msb;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:   if (Start) state_nxt = S_SHL_LO;
            S_SHL_LO: state_nxt = S_SHL_HI;
            S_SHL_HI: begin
                if (b_reg[cnt])       state_nxt = S_ADD_LO;
                else if (cnt == '0)   state_nxt = S_DONE;
                else                  state_nxt = S_SHL_LO;
            end
            S_ADD_LO: state_nxt = S_ADD_HI;
            S_ADD_HI: state_nxt = (cnt == '0) ? S_DONE : S_SHL_LO;
            S_DONE:   state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        AluOp = OP_ADD;
        AluA  = '0;
        AluB  = '0;
        AluSC = 1'b0;
        case (state)
            S_SHL_LO: begin
                AluOp = OP_LSH;
                AluA  = lo;
            end
            S_SHL_HI: begin
                // Bit shifted out of Lo in the previous cycle enters Hi's LSB.
                AluOp = OP_LSH;
                AluA  = hi;
                AluSC = lo_msb;
            end
            S_ADD_LO: begin
                AluA = lo;
                AluB = a_reg;
            end
            S_ADD_HI: begin
                AluA = hi;
                AluB = W'(carry);
            end
            default: ;
        endcase
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            a_reg  <= '0;
            b_reg  <= '0;
            hi     <= '0;
            lo     <= '0;
            cnt    <= CW'(W - 1);
            carry  <= 1'b0;
            lo_msb <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (Start) begin
                        a_reg <= OpA;
                        b_reg <= OpB;
                        hi    <= '0;
                        lo    <= '0;
                        cnt   <= CW'(W - 1);
                    end
                end
                S_SHL_LO: begin
                    lo     <= AluOut;
                    lo_msb <= lo[W-1];
                end
                S_SHL_HI: begin
                    hi <= AluOut;
                    if (!b_reg[cnt] && cnt != '0) cnt <= cnt - 1'b1;
                end
                S_ADD_LO: begin
                    lo    <= AluOut;
                    carry <= (AluOut < lo);
                end
                S_ADD_HI: begin
                    hi <= AluOut;
                    if (cnt != '0) cnt <= cnt - 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign Busy    = (state != S_IDLE);
    assign Done    = (state == S_DONE);
    assign Product = {hi, lo};

endmodule

// File: tb/tb_alu_mul_sequencer.sv
// tb/tb_alu_mul_sequencer.sv - scoreboard bench for alu_mul_sequencer with behavioural ALU
module tb_alu_mul_sequencer;

    localparam int          W      = 8;
    localparam int          OPS    = 3;
    localparam logic [2:0]  OP_ADD = 3'd2;
    localparam logic [2:0]  OP_LSH = 3'd5;

    logic             Clk = 1'b0;
    logic             Reset_n = 1'b0;
    logic             Start = 1'b0;
    logic [W-1:0]     OpA = '0;
    logic [W-1:0]     OpB = '0;
    logic             Busy;
    logic             Done;
    logic [2*W-1:0]   Product;
    logic [W-1:0]     alu_a;
    logic [W-1:0]     alu_b;
    logic [OPS-1:0]   alu_op;
    logic             alu_sc;
    logic [W-1:0]     alu_out;

    alu_mul_sequencer #(.W(W), .Ops(OPS), .OP_ADD(OP_ADD), .OP_LSH(OP_LSH)) dut (
        .Clk(Clk), .Reset_n(Reset_n), .Start(Start), .OpA(OpA), .OpB(OpB),
        .Busy(Busy), .Done(Done), .Product(Product),
        .AluA(alu_a), .AluB(alu_b), .AluOp(alu_op), .AluSC(alu_sc), .AluOut(alu_out)
    );

    always #5 Clk = ~Clk;

    // Behavioural ALU: ADD = a+b+sc, LSH = shift left with sc entering the LSB.
    assign alu_out = (alu_op == OP_LSH) ? {alu_a[W-2:0], alu_sc} :
                     (alu_op == OP_ADD) ? W'(alu_a + alu_b + W'(alu_sc)) : '0;

    typedef struct {
        logic [2*W-1:0] prod;
        int             acc;
        int             lat;
        int             pop;
    } exp_t;

    exp_t            sb[$];
    exp_t            got;
    int              cyc = 0;
    int              tests = 0;
    int              fails = 0;
    int              free_edge = 0;
    int              last_acc = -100;
    int              last_lat = 0;
    bit              started = 1'b0;
    logic [2*W-1:0]  hold_exp = '0;
    int              n_add = 0;
    int              n_lsh = 0;

    always @(posedge Clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference handshake model: accept when idle, done L cycles later, idle again 2 edges after.
    task automatic drive(input bit st, input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t e;
        Start = st;
        OpA   = a;
        OpB   = b;
        if (st && (cyc + 1) >= free_edge) begin
            e.prod    = {{W{1'b0}}, a} * {{W{1'b0}}, b};
            e.acc     = cyc + 1;
            e.pop     = $countones(b);
            e.lat     = 2 * W + 2 * e.pop;
            sb.push_back(e);
            started   = 1'b1;
            last_acc  = e.acc;
            last_lat  = e.lat;
            free_edge = e.acc + e.lat + 2;
        end
        @(negedge Clk);
    endtask

    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b);
        drive(1'b1, a, b);
        while (cyc + 1 < free_edge) drive(1'b0, W'($urandom), W'($urandom));
    endtask

    function automatic logic [W-1:0] pick();
        case ($urandom_range(0, 3))
            0:       return '0;
            1:       return '1;
            default: return W'($urandom);
        endcase
    endfunction

    always @(negedge Clk) begin
        if (!Reset_n) begin
            n_add = 0;
            n_lsh = 0;
        end else begin
            check("busy", 32'(Busy), 32'(started && cyc >= last_acc && cyc <= last_acc + last_lat));
            check("done", 32'(Done), 32'(started && cyc == last_acc + last_lat));
            if (!Busy) check("hold_product", 32'(Product), 32'(hold_exp));
            if (Busy && !Done) begin
                if (alu_op == OP_ADD)      n_add++;
                else if (alu_op == OP_LSH) n_lsh++;
            end
            if (Done) begin
                if (sb.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_done: got Done=1 expected no pending op (cycle %0d)", cyc);
                end else begin
                    got = sb.pop_front();
                    check("product", 32'(Product), 32'(got.prod));
                    check("latency", 32'(cyc - got.acc), 32'(got.lat));
                    check("add_ops", 32'(n_add), 32'(2 * got.pop));
                    check("lsh_ops", 32'(n_lsh), 32'(2 * W));
                    hold_exp = got.prod;
                end
                n_add = 0;
                n_lsh = 0;
            end
        end
    end

    initial begin
        repeat (2) @(negedge Clk);
        check("rst_busy", 32'(Busy), 32'd0);
        check("rst_done", 32'(Done), 32'd0);
        check("rst_product", 32'(Product), 32'd0);
        check("rst_aluop", 32'(alu_op), 32'(OP_ADD));
        check("rst_alua", 32'(alu_a), 32'd0);
        check("rst_alusc", 32'(alu_sc), 32'd0);
        Reset_n = 1'b1;
        @(negedge Clk);

        run_op(8'h0D, 8'h0B);
        run_op(8'hFF, 8'hFF);
        run_op(8'h5A, 8'h00);
        run_op(8'hFF, 8'h03);
        run_op(8'h01, 8'h80);

        for (int i = 0; i < 40; i++) drive(1'b1, W'($urandom), W'($urandom));
        while (cyc + 1 < free_edge) drive(1'b0, W'($urandom), W'($urandom));

        for (int i = 0; i < 1500; i++) drive(1'($urandom_range(0, 1)), pick(), pick());
        while (cyc + 1 < free_edge) drive(1'b0, '0, '0);

        drive(1'b1, 8'hC3, 8'hA5);
        repeat (6) drive(1'b0, W'($urandom), W'($urandom));
        @(posedge Clk);
        #2;
        Reset_n  = 1'b0;
        started  = 1'b0;
        sb.delete();
        hold_exp = '0;
        #1;
        check("abort_busy", 32'(Busy), 32'd0);
        check("abort_done", 32'(Done), 32'd0);
        check("abort_product", 32'(Product), 32'd0);
        @(negedge Clk);
        @(negedge Clk);
        Reset_n   = 1'b1;
        free_edge = 0;
        repeat (40) drive(1'b0, W'($urandom), W'($urandom));
        run_op(8'h0D, 8'h0B);

        Start = 1'b0;
        for (int i = 0; i < 100 && sb.size() > 0; i++) @(negedge Clk);
        tests++;
        if (sb.size() > 0) begin
            fails++;
            $display("FAIL drain: got %0d pending results expected 0", sb.size());
        end
        repeat (3) @(negedge Clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
